// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one pipelined fixed-point divider among N_REQ
// requesters, routing results back through per-requester 2-entry response FIFOs.
module div_arbiter #(
  parameter int WIDTH       = 16,
  parameter int Q_BITS      = 12,
  parameter int N_REQ       = 4,
  parameter int DIV_LATENCY = WIDTH + Q_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [N_REQ*WIDTH-1:0] resp_quotient,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic                   div_valid,
  output logic                   err
);

  // Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a response transfers on a cycle where resp_valid[i] & resp_ready[i].
  // valid must not wait on ready; ready never depends on resp-side inputs.

  if (N_REQ < 2 || N_REQ > 8 || Q_BITS >= WIDTH || DIV_LATENCY < 1) begin : g_bad_params
    $error("div_arbiter: unsupported parameter set");
  end

  localparam int TAG_W = $clog2(N_REQ);

  logic [1:0]       credit [N_REQ];
  logic [TAG_W-1:0] rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] next_ptr;
  logic [TAG_W-1:0] issue_tag;

  logic             pipe_vld [DIV_LATENCY];
  logic [TAG_W-1:0] pipe_tag [DIV_LATENCY];
  logic             wr_hit;

  logic [WIDTH-1:0] buf_mem [N_REQ][2];
  logic [N_REQ-1:0] buf_rd;
  logic [N_REQ-1:0] buf_wr;
  logic [1:0]       buf_cnt [N_REQ];
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;

  // Round-robin search starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    logic [TAG_W:0]   sum;
    logic [TAG_W-1:0] idx;
    eligible  = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (credit[i] != 2'd2);
    end
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(N_REQ)) sum = sum - (TAG_W+1)'(N_REQ);
      idx = sum[TAG_W-1:0];
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    next_ptr = (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
  end

  assign req_ready = grant;
  assign wr_hit    = div_valid && pipe_vld[DIV_LATENCY-1];

  // Response FIFO view; quotient reads zero while a buffer is empty.
  always_comb begin
    resp_valid    = '0;
    resp_quotient = '0;
    push          = '0;
    pop           = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (buf_cnt[i] != 2'd0) begin
        resp_valid[i] = 1'b1;
        resp_quotient[i*WIDTH +: WIDTH] = buf_mem[i][buf_rd[i]];
      end
      pop[i]  = resp_valid[i] && resp_ready[i];
      push[i] = wr_hit && (pipe_tag[DIV_LATENCY-1] == TAG_W'(i)) && (buf_cnt[i] != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      issue_tag    <= '0;
      err          <= 1'b0;
      buf_rd       <= '0;
      buf_wr       <= '0;
      for (int s = 0; s < DIV_LATENCY; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_tag[s] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        credit[i]     <= 2'd0;
        buf_cnt[i]    <= 2'd0;
        buf_mem[i][0] <= '0;
        buf_mem[i][1] <= '0;
      end
    end else begin
      div_start    <= grant_any;
      div_dividend <= grant_any ? req_dividend[grant_idx*WIDTH +: WIDTH] : '0;
      div_divisor  <= grant_any ? req_divisor[grant_idx*WIDTH +: WIDTH] : '0;
      issue_tag    <= grant_idx;
      if (grant_any) rr_ptr <= next_ptr;

      // Tag pipeline is fed from the registered issue so it lines up with div_valid.
      pipe_vld[0] <= div_start;
      pipe_tag[0] <= issue_tag;
      for (int s = 1; s < DIV_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end

      if (div_valid != pipe_vld[DIV_LATENCY-1]) err <= 1'b1;

      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !pop[i])      credit[i] <= credit[i] + 2'd1;
        else if (!grant[i] && pop[i]) credit[i] <= credit[i] - 2'd1;

        if (push[i]) begin
          buf_mem[i][buf_wr[i]] <= div_quotient;
          buf_wr[i]             <= ~buf_wr[i];
        end
        if (pop[i]) buf_rd[i] <= ~buf_rd[i];

        if (push[i] && !pop[i])      buf_cnt[i] <= buf_cnt[i] + 2'd1;
        else if (!push[i] && pop[i]) buf_cnt[i] <= buf_cnt[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: models the shared fixed-point divider and checks
// arbitration, latency, credit backpressure, routing, reset and error detection.
module tb_div_arbiter;

  localparam int WIDTH  = 16;
  localparam int Q_BITS = 12;
  localparam int N_REQ  = 4;
  localparam int LAT    = 28;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic [N_REQ-1:0]       resp_valid;
  logic [N_REQ-1:0]       resp_ready;
  logic [N_REQ*WIDTH-1:0] resp_quotient;
  logic                   div_start;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic [WIDTH-1:0]       div_quotient;
  logic                   div_valid;
  logic                   err;
  logic                   inject;

  int n_cmp;
  int n_bad;

  div_arbiter #(
    .WIDTH(WIDTH), .Q_BITS(Q_BITS), .N_REQ(N_REQ), .DIV_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_quotient(resp_quotient),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_valid(div_valid), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- divider model ----------------
  function automatic logic [15:0] fx_div(input logic [15:0] a, input logic [15:0] b);
    longint num;
    longint den;
    longint q;
    if (b == 16'h0000) return a[15] ? 16'h8000 : 16'h7FFF;
    num = longint'($signed(a)) <<< Q_BITS;
    den = longint'($signed(b));
    q   = num / den;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  logic        dv_pipe [LAT];
  logic [15:0] dq_pipe [LAT];

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) begin
        dv_pipe[s] <= 1'b0;
        dq_pipe[s] <= 16'h0;
      end
    end else begin
      dv_pipe[0] <= div_start;
      dq_pipe[0] <= div_start ? fx_div(div_dividend, div_divisor) : 16'h0;
      for (int s = 1; s < LAT; s++) begin
        dv_pipe[s] <= dv_pipe[s-1];
        dq_pipe[s] <= dq_pipe[s-1];
      end
    end
  end

  assign div_valid    = dv_pipe[LAT-1] | inject;
  assign div_quotient = dq_pipe[LAT-1];

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] qslice(input int i);
    return resp_quotient[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_dividend[i*WIDTH +: WIDTH] = a;
    req_divisor[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    inject    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset        = 1'b1;
    req_valid    = '0;
    resp_ready   = '1;
    inject       = 1'b0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL rst_div_start: got %b want 0", div_start); end
    n_cmp++; if (div_dividend !== 16'h0 || div_divisor !== 16'h0) begin n_bad++; $display("FAIL rst_div_ops: got %h/%h want 0000/0000", div_dividend, div_divisor); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (resp_quotient !== 64'h0) begin n_bad++; $display("FAIL rst_quotient: got %h want 0", resp_quotient); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int          first;
    int          nseen;
    logic [15:0] got;
    first = 0; nseen = 0; got = 16'h0;
    do_reset();
    resp_ready = '1;
    set_op(0, 16'h1800, 16'h0800);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++; if (div_start !== 1'b1 || div_dividend !== 16'h1800 || div_divisor !== 16'h0800) begin
      n_bad++; $display("FAIL single_issue: got start=%b %h/%h want 1 1800/0800", div_start, div_dividend, div_divisor);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (div_start !== 1'b0 || div_dividend !== 16'h0 || div_divisor !== 16'h0) begin
      n_bad++; $display("FAIL single_idle: got start=%b %h/%h want 0 0000/0000", div_start, div_dividend, div_divisor);
    end
    for (int c = 3; c <= 45; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid[0]) begin
        nseen++;
        if (first == 0) begin first = c; got = qslice(0); end
      end
    end
    n_cmp++; if (first != 30) begin n_bad++; $display("FAIL single_latency: got %0d want 30", first); end
    n_cmp++; if (got !== 16'h3000) begin n_bad++; $display("FAIL single_quotient: got %h want 3000", got); end
    n_cmp++; if (nseen != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", nseen); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_rdy;
    logic [15:0] exp_q [4];
    int          cnt [4];
    exp_q[0] = 16'h1000; exp_q[1] = 16'h2000; exp_q[2] = 16'h0800; exp_q[3] = 16'hF800;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset();
    resp_ready = '1;
    set_op(0, 16'h1000, 16'h1000);
    set_op(1, 16'h2000, 16'h1000);
    set_op(2, 16'h0800, 16'h1000);
    set_op(3, 16'hF000, 16'h2000);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_rdy = 4'(1 << (k % 4));
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL rr_start[%0d]: got %b want 1", k, div_start); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_credit_limit: got %b want 0000", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (resp_valid[i]) begin
          cnt[i]++;
          n_cmp++; if (qslice(i) !== exp_q[i]) begin n_bad++; $display("FAIL rr_quotient[%0d]: got %h want %h", i, qslice(i), exp_q[i]); end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cnt[i] != 2) begin n_bad++; $display("FAIL rr_resp_count[%0d]: got %0d want 2", i, cnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    int hi;
    hi = 0;
    do_reset();
    resp_ready = 4'b1011;
    set_op(2, 16'h1000, 16'h0800);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_accept_a: got %b want 0100", req_ready); end
    @(negedge clk);
    set_op(2, 16'h0C00, 16'h1000);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_accept_b: got %b want 0100", req_ready); end
    @(negedge clk);
    set_op(2, 16'h3000, 16'h1000);
    set_op(0, 16'h0400, 16'h1000);
    req_valid = 4'b0101;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_other_runs: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready[2]) hi++;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL bp_stalled: got %0d ready cycles want 0", hi); end
    n_cmp++; if (resp_valid[2] !== 1'b1 || qslice(2) !== 16'h2000) begin
      n_bad++; $display("FAIL bp_head_a: got v=%b %h want 1 2000", resp_valid[2], qslice(2));
    end
    resp_ready[2] = 1'b1;
    @(negedge clk);
    resp_ready[2] = 1'b0;
    #1;
    n_cmp++; if (qslice(2) !== 16'h0C00) begin n_bad++; $display("FAIL bp_head_b: got %h want 0C00", qslice(2)); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_accept_c: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (35) @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[2] !== 1'b1 || qslice(2) !== 16'h0C00) begin
      n_bad++; $display("FAIL bp_hold_b: got v=%b %h want 1 0C00", resp_valid[2], qslice(2));
    end
    resp_ready[2] = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[2] !== 1'b1 || qslice(2) !== 16'h3000) begin
      n_bad++; $display("FAIL bp_head_c: got v=%b %h want 1 3000", resp_valid[2], qslice(2));
    end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[2] !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", resp_valid[2]); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bp_err: got %b want 0", err); end
  endtask

  task automatic test_div_zero();
    int          n1;
    int          n3;
    int          other;
    logic [15:0] q1;
    logic [15:0] q3;
    n1 = 0; n3 = 0; other = 0; q1 = 16'h0; q3 = 16'h0;
    do_reset();
    resp_ready = '1;
    set_op(1, 16'h1000, 16'h0000);
    set_op(3, 16'hF000, 16'h0000);
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL dz_grant1: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL dz_grant3: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid[1]) begin n1++; q1 = qslice(1); end
      if (resp_valid[3]) begin n3++; q3 = qslice(3); end
      if (resp_valid[0] || resp_valid[2]) other++;
    end
    n_cmp++; if (n1 != 1 || q1 !== 16'h7FFF) begin n_bad++; $display("FAIL dz_req1: got n=%0d %h want 1 7FFF", n1, q1); end
    n_cmp++; if (n3 != 1 || q3 !== 16'h8000) begin n_bad++; $display("FAIL dz_req3: got n=%0d %h want 1 8000", n3, q3); end
    n_cmp++; if (other != 0) begin n_bad++; $display("FAIL dz_misroute: got %0d want 0", other); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dz_err: got %b want 0", err); end
  endtask

  task automatic test_reset_midflight();
    int nv;
    int ne;
    nv = 0; ne = 0;
    do_reset();
    resp_ready = '1;
    set_op(0, 16'h1000, 16'h1000);
    set_op(1, 16'h2000, 16'h1000);
    set_op(2, 16'h0800, 16'h1000);
    req_valid = 4'b0111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mf_grant0: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mf_grant1: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mf_grant2: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (resp_valid != 4'b0000) nv++;
      if (err) ne++;
      @(negedge clk);
    end
    n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL mf_no_resp: got %0d cycles want 0", nv); end
    n_cmp++; if (ne != 0) begin n_bad++; $display("FAIL mf_err: got %0d cycles want 0", ne); end
    req_valid = 4'b1100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mf_rr_restart: got %b want 0100", req_ready); end
    req_valid  = 4'b0001;
    resp_ready = 4'b1110;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mf_credit_a: got %b want 0001", req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mf_credit_b: got %b want 0001", req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mf_credit_full: got %b want 0000", req_ready); end
    req_valid  = '0;
    resp_ready = '1;
  endtask

  task automatic test_spurious();
    do_reset();
    resp_ready = '1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sp_err_before: got %b want 0", err); end
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sp_err_set: got %b want 1", err); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (err !== 1'b1 || resp_valid !== 4'b0000) begin
        n_bad++; $display("FAIL sp_hold[%0d]: got err=%b v=%b want 1 0000", c, err, resp_valid);
      end
    end
    do_reset();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sp_err_cleared: got %b want 0", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_div_zero();
    test_reset_midflight();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
